// File: rtl/iteration_scheduler_pkg.sv
// iteration_scheduler_pkg
// Shared definitions for the iteration scheduler: the number of requesters
// and the sequencer state encoding.
// No ports (package).
package iteration_scheduler_pkg;

    localparam int NUM_REQ = 2;

    // IDLE waits for a request, RUN issues one step per clock, DONE pulses
    // completion for exactly one cycle before returning to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin arbiter.
// Ports:
//   valid     [1:0] in  : per-requester request valid
//   last            in  : index of the requester served most recently
//   grant     [1:0] out : one-hot grant, zero when nobody is valid
//   grant_idx       out : index of the granted requester (0 when idle)
module rr_arbiter2
    import iteration_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    // A lone requester always wins; on a tie the one that was not served
    // last goes next, so neither side can starve the other.
    always_comb begin
        grant_idx = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

    always_comb begin
        grant = '0;
        if (valid != '0) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/iteration_scheduler.sv
// iteration_scheduler
// Sequencer that serves two requesters round-robin and issues one toggle
// step per clock for each requested iteration, keeping a result bit per
// requester that flips on every one of its steps.
// Ports:
//   clock                 in  : sole clock, posedge
//   reset                 in  : asynchronous active-high reset
//   req_valid  [1:0]      in  : per-requester request valid
//   req_count  [1:0][W-1:0] in: per-requester iteration count
//   req_ready  [1:0]      out : accept strobe (combinational), one-hot or zero
//   step                  out : one pulse per iteration
//   owner                 out : requester being served (valid while busy)
//   busy                  out : high in RUN and DONE
//   done                  out : one-cycle completion pulse
//   done_owner            out : requester that completed (valid with done)
//   result     [1:0]      out : per-requester toggle state
module iteration_scheduler
    import iteration_scheduler_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0]   req_count,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  step,
    output logic                                  owner,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  done_owner,
    output logic [NUM_REQ-1:0]                    result
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic                     last_owner;
    logic [NUM_REQ-1:0]       grant;
    logic                     grant_idx;

    rr_arbiter2 u_arbiter (
        .valid     (req_valid),
        .last      (last_owner),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Requests are only accepted while idle; anything arriving later simply
    // stays pending on req_valid until the sequencer comes back.
    assign req_ready  = (state == IDLE) ? grant : '0;

    assign step       = (state == RUN);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign done_owner = owner;

    // Main sequencer. A zero count skips RUN entirely. The counter leaves RUN
    // when it reaches 1, so it never decrements through zero. last_owner is
    // updated only on completion, which makes the arbiter alternate between
    // requesters that are both continuously valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            owner      <= 1'b0;
            result     <= '0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != '0) begin
                        owner     <= grant_idx;
                        remaining <= req_count[grant_idx];
                        state     <= (req_count[grant_idx] == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    result    <= result ^ (2'b01 << owner);
                    remaining <= remaining - COUNT_ONE;
                    if (remaining == COUNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iteration_scheduler.sv
// tb_iteration_scheduler
// Self-checking bench for iteration_scheduler. A transaction-level model
// records each accepted job (start cycle, count, owner) and derives every
// cycle's expected outputs from the timing rules of the block.
module tb_iteration_scheduler;

    localparam int CW = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [1:0]           req_valid;
    logic [1:0][CW-1:0]   req_count;
    logic [1:0]           req_ready;
    logic                 step;
    logic                 owner;
    logic                 busy;
    logic                 done;
    logic                 done_owner;
    logic [1:0]           result;

    always #5 clock = ~clock;

    iteration_scheduler #(.COUNT_WIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .step       (step),
        .owner      (owner),
        .busy       (busy),
        .done       (done),
        .done_owner (done_owner),
        .result     (result)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int step_seen = 0;

    // Requester-side state: a request stays pending until it is accepted.
    bit pend [2];
    int pcnt [2];
    bit auto_gen  = 0;
    bit hold_both = 0;

    // Reference model: the job in flight and the results of finished jobs.
    bit         m_active;
    int         m_t;
    int         m_n;
    int         m_owner;
    logic [1:0] m_base;
    int         m_last;

    int hs_log[$];
    int hs_cycle[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_active = 0;
        m_t      = 0;
        m_n      = 0;
        m_owner  = 0;
        m_base   = 2'b00;
        m_last   = 1;
        pend[0]  = 0;
        pend[1]  = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_step"},       step,       0);
        checkOutput({tag, "_busy"},       busy,       0);
        checkOutput({tag, "_done"},       done,       0);
        checkOutput({tag, "_result"},     result,     0);
        checkOutput({tag, "_owner"},      owner,      0);
        checkOutput({tag, "_done_owner"}, done_owner, 0);
        checkOutput({tag, "_ready"},      req_ready,  0);
    endtask

    // Assert reset for one cycle with all requesters quiet, then release it.
    task automatic doReset();
        reset     = 1'b1;
        req_valid = 2'b00;
        @(negedge clock);
        #1;
        checkResetValues("reset");
        modelReset();
        reset = 1'b0;
    endtask

    // One clock cycle: drive requester inputs, compare against the model,
    // then let the model record any handshake that happens this cycle.
    task automatic applyStimulus();
        int         winner;
        int         k;
        bit         e_step;
        bit         e_done;
        bit         e_busy;
        logic [1:0] e_ready;
        logic [1:0] e_result;

        @(negedge clock);
        cyc++;
        for (int r = 0; r < 2; r++) begin
            if (hold_both && !pend[r]) begin
                pend[r] = 1;
                pcnt[r] = 1;
            end else if (auto_gen && !pend[r] && $urandom_range(0, 3) == 0) begin
                pend[r] = 1;
                pcnt[r] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            end
            req_valid[r] = pend[r];
            req_count[r] = pcnt[r][CW-1:0];
        end
        #1;

        // A job is over two cycles after its last step.
        if (m_active && cyc > m_t + m_n + 1) begin
            m_base[m_owner] = m_base[m_owner] ^ m_n[0];
            m_last   = m_owner;
            m_active = 0;
        end

        winner = -1;
        if (!m_active) begin
            if (req_valid == 2'b11)   winner = (m_last == 0) ? 1 : 0;
            else if (req_valid[0])    winner = 0;
            else if (req_valid[1])    winner = 1;
        end
        e_ready = (winner < 0) ? 2'b00 : (2'b01 << winner);

        e_step   = m_active && cyc <= m_t + m_n;
        e_done   = m_active && cyc == m_t + m_n + 1;
        e_busy   = m_active;
        e_result = m_base;
        if (m_active) begin
            k = cyc - m_t - 1;
            if (k > m_n) k = m_n;
            e_result[m_owner] = m_base[m_owner] ^ k[0];
        end

        checkOutput("ready",  req_ready, e_ready);
        checkOutput("step",   step,      e_step);
        checkOutput("done",   done,      e_done);
        checkOutput("busy",   busy,      e_busy);
        checkOutput("result", result,    e_result);
        if (e_busy) checkOutput("owner", owner, m_owner);
        if (e_done) checkOutput("done_owner", done_owner, m_owner);
        if (step) step_seen++;

        if (winner >= 0) begin
            m_active = 1;
            m_t      = cyc;
            m_n      = pcnt[winner];
            m_owner  = winner;
            pend[winner] = 0;
            hs_log.push_back(winner);
            hs_cycle.push_back(cyc);
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        int base;
        int t0;

        reset     = 1'b1;
        req_valid = 2'b00;
        req_count = '0;
        modelReset();
        #1;
        checkResetValues("por");

        // Single request, count 3, from requester 0.
        doReset();
        pend[0] = 1; pcnt[0] = 3;
        base = hs_log.size();
        runCycles(8);
        checkOutput("s1_accepts", hs_log.size() - base, 1);
        checkOutput("s1_result", result, 2'b01);

        // Count 0 from requester 1: completes without any step.
        pend[1] = 1; pcnt[1] = 0;
        step_seen = 0;
        runCycles(4);
        checkOutput("s2_steps", step_seen, 0);
        checkOutput("s2_result", result, 2'b01);

        // Both requesters continuously valid with count 1: strict alternation.
        doReset();
        base = hs_log.size();
        hold_both = 1;
        runCycles(12);
        hold_both = 0;
        runCycles(10);
        checkOutput("s3_accepts", (hs_log.size() - base >= 4) ? 1 : 0, 1);
        if (hs_log.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("s3_grant_order", hs_log[base + i], i % 2);
                if (i > 0) checkOutput("s3_interval", hs_cycle[base + i] - hs_cycle[base + i - 1], 3);
            end
        end

        // Requester 1 arrives while requester 0 runs a count of 4.
        doReset();
        base = hs_log.size();
        pend[0] = 1; pcnt[0] = 4;
        applyStimulus();
        t0 = cyc;
        pend[1] = 1; pcnt[1] = 2;
        runCycles(12);
        checkOutput("s4_accepts", hs_log.size() - base, 2);
        if (hs_log.size() - base == 2) begin
            checkOutput("s4_late_owner", hs_log[base + 1], 1);
            checkOutput("s4_late_cycle", hs_cycle[base + 1] - t0, 6);
        end

        // Reset in the middle of a count-5 run.
        doReset();
        pend[0] = 1; pcnt[0] = 5;
        runCycles(3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s5_step",   step,   0);
        checkOutput("s5_busy",   busy,   0);
        checkOutput("s5_done",   done,   0);
        checkOutput("s5_result", result, 0);
        @(negedge clock);
        #1;
        modelReset();
        reset = 1'b0;
        runCycles(8);
        base = hs_log.size();
        pend[0] = 1; pcnt[0] = 3;
        runCycles(8);
        checkOutput("s5_fresh_accepts", hs_log.size() - base, 1);
        checkOutput("s5_fresh_result", result, 2'b01);

        // Maximum count.
        doReset();
        step_seen = 0;
        pend[0] = 1; pcnt[0] = 255;
        runCycles(262);
        checkOutput("s6_steps", step_seen, 255);
        checkOutput("s6_result", result, 2'b01);

        // Random traffic from both requesters.
        doReset();
        auto_gen = 1;
        runCycles(1500);
        auto_gen = 0;
        runCycles(40);
        checkOutput("s7_drained", pend[0] | pend[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iteration_scheduler.md
# iteration_scheduler

Multi-cycle sequencer that replaces an unrolled in-cycle toggle loop with one toggle step per clock, shared between two requesters. Each requester submits an iteration count. The block arbitrates round-robin, then drives one `step` pulse per iteration into the shared toggle datapath while keeping a per-requester result bit. It signals `done` on completion. It sits between request sources and the toggle datapath, so loop-style behaviour maps to synthesizable, BLIF-friendly sequential logic.

## Interface
- `COUNT_WIDTH`, default 8: width of the iteration count. Maximum count is 2^COUNT_WIDTH−1.
- `clock`, input, 1: sole clock. All state updates on posedge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, [1:0]: per-requester request valid.
- `req_count`, input, [1:0][COUNT_WIDTH-1:0]: per-requester iteration count. Sampled only on handshake.
- `req_ready`, output, [1:0]: accept strobe, combinational, one-hot or zero.
- `step`, output, 1: one-cycle pulse per iteration to the datapath.
- `owner`, output, 1: index of the requester currently served. Valid while `busy`.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle completion pulse.
- `done_owner`, output, 1: requester that completed. Valid with `done`.
- `result`, output, [1:0]: per-requester toggle state. Bit toggles on each of its steps.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready` = arbiter grant, qualified by `req_valid`.
  - On handshake: latch `owner` and `remaining` = `req_count[owner]`.
  - Next state is DONE if the count is 0, otherwise RUN.
- RUN:
  - `step` = 1.
  - `result[owner]` toggles.
  - `remaining` decrements.
  - When `remaining` == 1, the next state is DONE.
  - `req_ready` = 0.
- DONE:
  - `done` = 1 and `done_owner` = `owner`.
  - `last_owner` ← `owner`.
  - Next state is IDLE. `req_ready` = 0.
- Arbitration:
  - If one valid, that requester wins.
  - If both valid, the requester ≠ `last_owner` wins.
- Requests arriving outside IDLE stay pending and are not dropped. The requester holds `req_valid` until it sees `req_ready`.
- `result` bits change only through steps. The final value of `result[k]` equals the prior value XOR the parity of the count.
- Counter arithmetic is unsigned COUNT_WIDTH. There is no wrap, because the decrement stops at 1.
- Reset values:
  - state = IDLE.
  - `step`, `busy`, `done` = 0.
  - `owner`, `done_owner` = 0.
  - `result` = 2'b00.
  - `remaining` = 0.
  - `last_owner` = 1, so requester 0 wins the first tie.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - No `done` is produced.
  - The interrupted requester's `result` bit clears.

## Timing
- Handshake at cycle T, with count N > 0:
  - `step` high during T+1 … T+N.
  - `done` during T+N+1.
  - Earliest next handshake at T+N+2.
- N = 0: no `step`, `done` during T+1, next handshake at T+2.
- Throughput: one handshake per N+2 cycles, or 2 cycles when N = 0.
- `req_ready` is combinational from state, `req_valid` and `last_owner`.
- All other outputs are registered or decoded from state.
- `step` and `done` are never high in the same cycle.

## Structure
- `iteration_scheduler_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - `localparam NUM_REQ = 2`.
- Sub-module `rr_arbiter2`:
  - Combinational two-way round-robin.
  - Inputs: `valid[1:0]`, `last`.
  - Outputs: `grant[1:0]`, `grant_idx`.
- Top level holds the FSM, `remaining` counter, `result` register and `last_owner`.

## Test plan
- Reset, then `req_valid` = 01 with count 3:
  - `req_ready[0]` at T.
  - `step` at T+1..T+3.
  - `result` = 01 after T+3.
  - `done` at T+4 with `done_owner` = 0.
- Count 0 from requester 1:
  - No `step`.
  - `done` at T+1 with `done_owner` = 1.
  - `result` unchanged.
- Both requesters held valid, count 1 each:
  - Grant sequence 0, 1, 0, 1.
  - Handshakes every 3 cycles.
- Requester 1 raises valid at T+1 while requester 0 runs count 4:
  - `req_ready[1]` stays low until T+6.
  - Accepted at T+6.
- Reset asserted during RUN at T+2 of a count-5 run:
  - `step`, `busy` and `result` go to 0 immediately.
  - No `done` follows.
  - A fresh request after reset behaves as in the first scenario.
- Count 255 (COUNT_WIDTH = 8):
  - Exactly 255 `step` pulses.
  - `result[owner]` = 1.
  - `done` at T+256.
